// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard/exception controller.
// Generates thermometer stall vectors from per-stage stall requests, and
// sequences a multi-cycle flush with a redirect PC when an exception arrives
// from the memory stage. An optional stall watchdog is compiled in when the
// macro PIPE_CTRL_WDOG_EN is defined; without it wdog_o is tied low.
module pipe_ctrl #(
  parameter int          STAGES    = 6,
  parameter int          FLUSH_CYC = 1,
  parameter logic [31:0] EBASE     = 32'h00000040,
  parameter logic [31:0] IVEC      = 32'h00000020,
  parameter int          WDOG_LIM  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stallreq_i,
  input  logic [31:0]       excepttype_i,
  input  logic [31:0]       cp0_epc_i,
  output logic [STAGES-1:0] stall,
  output logic              flush,
  output logic [31:0]       new_pc,
  output logic              wdog_o
);

  typedef enum logic {IDLE, FLUSH} state_t;

  localparam logic [3:0] FLUSH_LD = 4'(FLUSH_CYC);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       pc_q, pc_d;
  logic [STAGES-1:0] therm;
  logic [31:0]       code;

  // Redirect target for a nonzero exception code; eret returns to EPC.
  function automatic logic [31:0] vector_sel(input logic [31:0] c,
                                             input logic [31:0] epc);
    if (c == 32'h1)      return IVEC;
    else if (c == 32'he) return epc;
    else                 return EBASE;
  endfunction

  // Thermometer: a request at stage k holds every stage at or below k.
  always_comb begin
    logic acc;
    acc   = 1'b0;
    therm = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      acc      = acc | stallreq_i[k];
      therm[k] = acc;
    end
  end

`ifdef PIPE_CTRL_WDOG_EN
  localparam logic [15:0] WLIM = 16'(WDOG_LIM);

  logic [15:0] wcnt_q;
  logic        wdog_hit;

  assign wdog_hit = (wcnt_q == WLIM);
  // A real exception wins over the watchdog; a timeout acts as code 0xf.
  assign code     = (excepttype_i != 32'h0) ? excepttype_i :
                    (wdog_hit ? 32'hf : 32'h0);
  assign wdog_o   = rst && (state_q == IDLE) && wdog_hit;

  // Count consecutive stalled IDLE cycles; any unstalled cycle or flush clears it.
  always_ff @(posedge clk) begin
    if (!rst)
      wcnt_q <= '0;
    else if ((state_q == IDLE) && (stall != '0))
      wcnt_q <= wcnt_q + 16'd1;
    else
      wcnt_q <= '0;
  end
`else
  assign code   = excepttype_i;
  assign wdog_o = 1'b0;
`endif

  // State, flush counter and redirect PC registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
    end
  end

  // Next-state and outputs; reset low masks stall and flush immediately.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    stall   = '0;
    flush   = 1'b0;
    case (state_q)
      IDLE: begin
        if (code != 32'h0) begin
          state_d = FLUSH;
          cnt_d   = FLUSH_LD;
          pc_d    = vector_sel(code, cp0_epc_i);
        end else begin
          stall = therm;
        end
      end
      FLUSH: begin
        flush = 1'b1;
        if (cnt_q <= 4'd1) begin
          state_d = IDLE;
          cnt_d   = '0;
          pc_d    = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        pc_d    = '0;
      end
    endcase
    if (!rst) begin
      stall = '0;
      flush = 1'b0;
    end
  end

  assign new_pc = pc_q;

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter STAGES, default 6: number of pipeline stages; stage 0 is PC, stage STAGES-1 is writeback.
REQ-002 SHALL have parameter FLUSH_CYC, default 1: cycles flush is held per exception (legal range 1..15).
REQ-003 SHALL have parameter EBASE, default 32'h00000040: general exception vector.
REQ-004 SHALL have parameter IVEC, default 32'h00000020: interrupt vector.
REQ-005 SHALL have parameter WDOG_LIM, default 1024: stall-watchdog limit in cycles (legal range 2..65535).
REQ-006 SHALL have port clk, input, 1: single clock, rising edge.
REQ-007 SHALL have port rst, input, 1: reset, synchronous, active-low.
REQ-008 SHALL have port stallreq_i, input, STAGES: bit k is a stall request from stage k.
REQ-009 SHALL have port excepttype_i, input, 32: exception code from the memory stage; zero means none.
REQ-010 SHALL have port cp0_epc_i, input, 32: EPC for eret.
REQ-011 SHALL have port stall, output, STAGES: bit k holds stage k.
REQ-012 SHALL have port flush, output, 1: pipeline flush.
REQ-013 SHALL have port new_pc, output, 32: redirect target, valid while flush=1.
REQ-014 SHALL have port wdog_o, output, 1: one-cycle watchdog-timeout pulse (tied 0 when the watchdog is compiled out).

Function
REQ-015 SHALL have a two-state FSM, IDLE and FLUSH, with a 4-bit flush counter.
REQ-016 SHALL, in IDLE, drive stall combinationally as a thermometer: for highest set bit k of stallreq_i, bits 0..k = 1, others 0; all zero if no request.
REQ-017 SHALL, in IDLE with excepttype_i != 0, drive stall = 0 in that cycle, register new_pc, load counter = FLUSH_CYC, and enter FLUSH at the next edge.
REQ-018 SHALL map exception codes to new_pc: 0x1 -> IVEC; 0xe -> cp0_epc_i sampled in the detection cycle; any other nonzero code -> EBASE.
REQ-019 SHALL, in FLUSH, drive flush = 1, stall = 0, hold new_pc, ignore stallreq_i and excepttype_i, and decrement the counter each cycle.
REQ-020 SHALL leave FLUSH for IDLE at the edge where the counter reaches 1, so flush is high exactly FLUSH_CYC consecutive cycles, starting one cycle after detection.
REQ-021 SHALL drive flush = 0 in IDLE; new_pc SHALL be zero in IDLE.
REQ-022 SHALL process an exception present on the cycle IDLE is re-entered as a new exception (back-to-back gap of exactly one cycle).
REQ-023 SHALL raise an exception in the same cycle as a stall request with exception priority: stall = 0.

Reset
REQ-024 SHALL, when rst = 0 at a rising edge, force state IDLE, counter 0, new_pc 0, watchdog count 0, and wdog_o 0; while rst = 0, stall = 0 and flush = 0.
REQ-025 SHALL abort a flush in progress when reset is asserted mid-FLUSH; flush is 0 from that edge.

Configuration
REQ-026 SHALL compile the stall watchdog only when macro PIPE_CTRL_WDOG_EN is defined.
REQ-027 SHALL, with PIPE_CTRL_WDOG_EN, count consecutive IDLE cycles with stall != 0 (counter clears on any cycle with stall = 0 or in FLUSH).
REQ-028 SHALL, on reaching WDOG_LIM, pulse wdog_o for one cycle, treat the event as exception code 0xf (new_pc = EBASE), and enter FLUSH.
REQ-029 SHALL, without PIPE_CTRL_WDOG_EN, contain no watchdog logic, tie wdog_o to 0, and leave stall unbounded.

Verification
REQ-030 SHALL check: stallreq_i=6'b001000, no exception -> stall=6'b001111, flush=0 the same cycle.
REQ-031 SHALL check: excepttype_i=0x8 for one cycle, FLUSH_CYC=3 -> flush=1 for cycles +1..+3, new_pc=0x40, stall=0 throughout.
REQ-032 SHALL check: excepttype_i=0xe with cp0_epc_i=0x1234 -> new_pc=0x1234 on the next cycle; cp0_epc_i changing during FLUSH does not alter new_pc.
REQ-033 SHALL check: excepttype_i=0x1 together with stallreq_i=6'b111111 -> stall=0 that cycle, flush=1 next cycle, new_pc=0x20.
REQ-034 SHALL check: rst=0 in the 2nd cycle of a FLUSH_CYC=4 flush -> flush=0 and new_pc=0 from that edge; IDLE after release.
REQ-035 SHALL check, with PIPE_CTRL_WDOG_EN and WDOG_LIM=8: stallreq_i held at 6'b000100 -> wdog_o pulses after 8 stalled cycles, flush=1 next cycle, new_pc=0x40.
